// File: rtl/minibus_ram_arbiter_if.sv
// rtl/minibus_ram_arbiter_if.sv - minibus request/response bundle shared by masters, arbiter and RAM slave
//
// Signals (direction as seen from the bus master):
//   sel    out  slave select (driven on the slave-side bus only; masters tie it low)
//   ren    out  read enable, held until ack or err
//   wen    out  write enable, held until ack or err
//   addr   out  BIT_WIDTH byte address
//   wdata  out  BIT_WIDTH write data
//   width  out  2-bit access width (00 byte, 01 half, 10 word)
//   rdata  in   BIT_WIDTH read data
//   ack    in   one-cycle completion pulse
//   err    in   one-cycle error/abort pulse
interface minibus_ram_arbiter_if #(
  parameter int BIT_WIDTH = 32
);
  logic                 sel;
  logic                 ren;
  logic                 wen;
  logic [BIT_WIDTH-1:0] addr;
  logic [BIT_WIDTH-1:0] wdata;
  logic [1:0]           width;
  logic [BIT_WIDTH-1:0] rdata;
  logic                 ack;
  logic                 err;

  modport master (
    output sel, ren, wen, addr, wdata, width,
    input  rdata, ack, err
  );

  modport slave (
    input  sel, ren, wen, addr, wdata, width,
    output rdata, ack, err
  );
endinterface

// File: rtl/minibus_ram_arbiter.sv
// rtl/minibus_ram_arbiter.sv - two-master arbiter in front of a single RAM minibus slave
//
// Parameters:
//   BIT_WIDTH  address/data width
//   TIMEOUT    BUSY cycles without slave response before the transfer is aborted (2..255)
// Ports:
//   clk   rising-edge clock
//   nrst  asynchronous active-low reset
//   m0    master 0 bus (arbiter acts as slave)
//   m1    master 1 bus (arbiter acts as slave)
//   s     RAM slave bus (arbiter acts as master)
// Build option:
//   MINIBUS_ARB_RR_EN  defined: round-robin between simultaneous requests;
//                      undefined: master 0 has fixed priority.
module minibus_ram_arbiter #(
  parameter int BIT_WIDTH = 32,
  parameter int TIMEOUT   = 15
) (
  input logic                    clk,
  input logic                    nrst,
  minibus_ram_arbiter_if.slave   m0,
  minibus_ram_arbiter_if.slave   m1,
  minibus_ram_arbiter_if.master  s
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t               state, state_nxt;
  logic                 grant, grant_nxt;
  logic                 last_grant, last_grant_nxt;
  logic [7:0]           cnt, cnt_nxt;

  logic                 req0, req1, grant_pick;
  logic                 g_ren, g_wen;
  logic [BIT_WIDTH-1:0] g_addr, g_wdata;
  logic [1:0]           g_width;
  logic                 ack_g, err_g, route_rdata;

  // Masters never drive a meaningful select; it only exists on the slave side.
  logic unused_master_sel;
  assign unused_master_sel = m0.sel ^ m1.sel;

  always_comb begin
    req0    = m0.ren | m0.wen;
    req1    = m1.ren | m1.wen;
    g_ren   = grant ? m1.ren   : m0.ren;
    g_wen   = grant ? m1.wen   : m0.wen;
    g_addr  = grant ? m1.addr  : m0.addr;
    g_wdata = grant ? m1.wdata : m0.wdata;
    g_width = grant ? m1.width : m0.width;
  end

  // Arbitration decision taken while IDLE; only meaningful when some request is up.
  always_comb begin
`ifdef MINIBUS_ARB_RR_EN
    grant_pick = (req0 && req1) ? ~last_grant : req1;
`else
    grant_pick = ~req0;
`endif
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= 8'd0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      cnt        <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    cnt_nxt        = cnt;
    ack_g          = 1'b0;
    err_g          = 1'b0;
    route_rdata    = 1'b0;
    s.sel          = 1'b0;
    s.ren          = 1'b0;
    s.wen          = 1'b0;
    s.addr         = '0;
    s.wdata        = '0;
    s.width        = 2'b00;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nxt = BUSY;
          grant_nxt = grant_pick;
          cnt_nxt   = 8'd0;
        end
      end
      BUSY: begin
        s.sel       = 1'b1;
        s.ren       = g_ren;
        s.wen       = g_wen;
        s.addr      = g_addr;
        s.wdata     = g_wdata;
        s.width     = g_width;
        route_rdata = 1'b1;
        if (!(g_ren || g_wen)) begin
          // Master withdrew its request: abandon silently, no pulse either way.
          state_nxt = IDLE;
        end else if (s.ack || s.err) begin
          // An ack landing on the timeout cycle wins; err only if the slave said so.
          ack_g          = s.ack;
          err_g          = s.err;
          state_nxt      = IDLE;
          last_grant_nxt = grant;
        end else if (cnt == TIMEOUT_LAST) begin
          err_g          = 1'b1;
          state_nxt      = IDLE;
          last_grant_nxt = grant;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    m0.ack   = ack_g & ~grant;
    m1.ack   = ack_g &  grant;
    m0.err   = err_g & ~grant;
    m1.err   = err_g &  grant;
    m0.rdata = (route_rdata && !grant) ? s.rdata : '0;
    m1.rdata = (route_rdata &&  grant) ? s.rdata : '0;
  end

endmodule

// File: tb/tb_minibus_ram_arbiter.sv
// tb/tb_minibus_ram_arbiter.sv - directed self-checking bench for minibus_ram_arbiter
module tb_minibus_ram_arbiter;

  localparam int BW = 32;

  logic clk;
  logic nrst;
  int   checks;
  int   errors;
  int   slave_mode;         // 0 never responds, 1 ack, 2 err
  logic [BW-1:0] slave_data;

  minibus_ram_arbiter_if #(.BIT_WIDTH(BW)) m0_if ();
  minibus_ram_arbiter_if #(.BIT_WIDTH(BW)) m1_if ();
  minibus_ram_arbiter_if #(.BIT_WIDTH(BW)) s_if ();

  minibus_ram_arbiter #(.BIT_WIDTH(BW), .TIMEOUT(15)) dut (
    .clk  (clk),
    .nrst (nrst),
    .m0   (m0_if.slave),
    .m1   (m1_if.slave),
    .s    (s_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered one-cycle RAM slave: responds the cycle after it sees sel.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s_if.ack   <= 1'b0;
      s_if.err   <= 1'b0;
      s_if.rdata <= '0;
    end else begin
      s_if.ack   <= (slave_mode == 1) && s_if.sel && !s_if.ack && !s_if.err;
      s_if.err   <= (slave_mode == 2) && s_if.sel && !s_if.ack && !s_if.err;
      s_if.rdata <= slave_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    #3;
    checks++; if (s_if.sel !== 1'b0) begin errors++; $display("FAIL reset_s_sel got=%b exp=0", s_if.sel); end
    checks++; if ({s_if.ren, s_if.wen, s_if.addr} !== '0) begin errors++; $display("FAIL reset_s_bus got=%h exp=0", {s_if.ren, s_if.wen, s_if.addr}); end
    checks++; if ({m0_if.ack, m0_if.err, m1_if.ack, m1_if.err} !== 4'b0) begin errors++; $display("FAIL reset_pulses got=%b exp=0000", {m0_if.ack, m0_if.err, m1_if.ack, m1_if.err}); end
    step();
    nrst = 1'b1;
    step();
  endtask

  task automatic test_read();
    slave_mode = 1; slave_data = 32'hDEADBEEF;
    m0_if.ren = 1'b1; m0_if.addr = 32'h10; m0_if.width = 2'b10;
    @(negedge clk);
    checks++; if (s_if.sel !== 1'b0) begin errors++; $display("FAIL read_c0_sel got=%b exp=0", s_if.sel); end
    step(); @(negedge clk);
    checks++; if (s_if.sel !== 1'b1) begin errors++; $display("FAIL read_c1_sel got=%b exp=1", s_if.sel); end
    checks++; if (s_if.ren !== 1'b1 || s_if.wen !== 1'b0) begin errors++; $display("FAIL read_c1_en got=%b%b exp=10", s_if.ren, s_if.wen); end
    checks++; if (s_if.addr !== 32'h10) begin errors++; $display("FAIL read_c1_addr got=%h exp=00000010", s_if.addr); end
    checks++; if (m0_if.ack !== 1'b0) begin errors++; $display("FAIL read_c1_ack got=%b exp=0", m0_if.ack); end
    step(); @(negedge clk);
    checks++; if (m0_if.ack !== 1'b1) begin errors++; $display("FAIL read_c2_ack got=%b exp=1", m0_if.ack); end
    checks++; if (m0_if.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_c2_rdata got=%h exp=deadbeef", m0_if.rdata); end
    checks++; if (m1_if.ack !== 1'b0 || m1_if.rdata !== '0) begin errors++; $display("FAIL read_c2_m1 got=%b/%h exp=0/0", m1_if.ack, m1_if.rdata); end
    step();
    m0_if.ren = 1'b0;
    @(negedge clk);
    checks++; if (s_if.sel !== 1'b0 || m0_if.ack !== 1'b0) begin errors++; $display("FAIL read_c3_idle got=%b%b exp=00", s_if.sel, m0_if.ack); end
    step();
  endtask

  task automatic test_write();
    slave_mode = 1;
    m1_if.wen = 1'b1; m1_if.addr = 32'h24; m1_if.wdata = 32'h12345678; m1_if.width = 2'b10;
    step(); @(negedge clk);
    checks++; if (s_if.wen !== 1'b1 || s_if.ren !== 1'b0) begin errors++; $display("FAIL write_en got=%b%b exp=01", s_if.ren, s_if.wen); end
    checks++; if (s_if.addr !== 32'h24 || s_if.wdata !== 32'h12345678) begin errors++; $display("FAIL write_bus got=%h/%h exp=00000024/12345678", s_if.addr, s_if.wdata); end
    checks++; if (s_if.width !== 2'b10) begin errors++; $display("FAIL write_width got=%b exp=10", s_if.width); end
    checks++; if (m1_if.ack !== 1'b0) begin errors++; $display("FAIL write_early_ack got=%b exp=0", m1_if.ack); end
    step(); @(negedge clk);
    checks++; if (m1_if.ack !== 1'b1 || m0_if.ack !== 1'b0) begin errors++; $display("FAIL write_ack got=%b%b exp=10", m1_if.ack, m0_if.ack); end
    step();
    m1_if.wen = 1'b0;
    step();
  endtask

  task automatic test_arbitration();
    int order [4];
    int exp_order [4];
    int n;
`ifdef MINIBUS_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    order = '{-1, -1, -1, -1};
    n = 0;
    slave_mode = 1;
    m0_if.ren = 1'b1; m0_if.addr = 32'h100;
    m1_if.ren = 1'b1; m1_if.addr = 32'h200;
    for (int c = 0; c < 20 && n < 4; c++) begin
      @(negedge clk);
      checks++; if (m0_if.ack && m1_if.ack) begin errors++; $display("FAIL arb_double_ack got=11 exp=one-hot"); end
      if (m0_if.ack) begin order[n] = 0; n++; end
      else if (m1_if.ack) begin order[n] = 1; n++; end
      step();
    end
    m0_if.ren = 1'b0; m1_if.ren = 1'b0;
    checks++; if (n !== 4) begin errors++; $display("FAIL arb_count got=%0d exp=4", n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (order[i] !== exp_order[i]) begin errors++; $display("FAIL arb_order[%0d] got=%0d exp=%0d", i, order[i], exp_order[i]); end
    end
    step();
  endtask

  task automatic test_slave_err();
    slave_mode = 2;
    m1_if.ren = 1'b1; m1_if.addr = 32'h30;
    step(); step(); @(negedge clk);
    checks++; if (m1_if.err !== 1'b1 || m1_if.ack !== 1'b0) begin errors++; $display("FAIL slave_err got=%b%b exp=10", m1_if.err, m1_if.ack); end
    checks++; if (m0_if.err !== 1'b0) begin errors++; $display("FAIL slave_err_m0 got=%b exp=0", m0_if.err); end
    step();
    m1_if.ren = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    int busy, errs, err_at, acks;
    busy = 0; errs = 0; err_at = 0; acks = 0;
    slave_mode = 0;
    m0_if.ren = 1'b1; m0_if.addr = 32'h44;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (s_if.sel) busy++;
      if (m0_if.err) begin errs++; err_at = busy; end
      if (m0_if.ack) acks++;
      step();
      if (errs != 0) break;
    end
    m0_if.ren = 1'b0;
    @(negedge clk);
    checks++; if (s_if.sel !== 1'b0) begin errors++; $display("FAIL timeout_idle got=%b exp=0", s_if.sel); end
    for (int c = 0; c < 3; c++) begin
      step(); @(negedge clk);
      if (m0_if.err) errs++;
    end
    checks++; if (errs !== 1) begin errors++; $display("FAIL timeout_err_count got=%0d exp=1", errs); end
    checks++; if (err_at !== 15) begin errors++; $display("FAIL timeout_err_cycle got=%0d exp=15", err_at); end
    checks++; if (acks !== 0) begin errors++; $display("FAIL timeout_ack got=%0d exp=0", acks); end
    step();
  endtask

  task automatic test_drop();
    slave_mode = 0;
    m0_if.ren = 1'b1; m0_if.addr = 32'h50;
    step();
    m0_if.ren = 1'b0;
    m1_if.ren = 1'b1; m1_if.addr = 32'h60;
    @(negedge clk);
    checks++; if (s_if.sel !== 1'b1 || s_if.addr !== 32'h50) begin errors++; $display("FAIL drop_busy got=%b/%h exp=1/00000050", s_if.sel, s_if.addr); end
    checks++; if (m0_if.ack !== 1'b0 || m0_if.err !== 1'b0) begin errors++; $display("FAIL drop_pulse got=%b%b exp=00", m0_if.ack, m0_if.err); end
    step(); @(negedge clk);
    checks++; if (s_if.sel !== 1'b0) begin errors++; $display("FAIL drop_idle got=%b exp=0", s_if.sel); end
    step();
    slave_mode = 1;
    @(negedge clk);
    checks++; if (s_if.sel !== 1'b1 || s_if.addr !== 32'h60) begin errors++; $display("FAIL drop_m1_grant got=%b/%h exp=1/00000060", s_if.sel, s_if.addr); end
    step(); @(negedge clk);
    checks++; if (m1_if.ack !== 1'b1) begin errors++; $display("FAIL drop_m1_ack got=%b exp=1", m1_if.ack); end
    step();
    m1_if.ren = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_busy();
    int pulses, ack_at;
    pulses = 0; ack_at = -1;
    slave_mode = 1;
    m0_if.ren = 1'b1; m0_if.addr = 32'h70;
    step();
    checks++; if (s_if.sel !== 1'b1) begin errors++; $display("FAIL rst_busy_pre got=%b exp=1", s_if.sel); end
    nrst = 1'b0;
    #1;
    checks++; if ({s_if.sel, s_if.ren, s_if.addr} !== '0) begin errors++; $display("FAIL rst_busy_outputs got=%h exp=0", {s_if.sel, s_if.ren, s_if.addr}); end
    checks++; if ({m0_if.ack, m0_if.err, m0_if.rdata} !== '0) begin errors++; $display("FAIL rst_busy_m0 got=%h exp=0", {m0_if.ack, m0_if.err, m0_if.rdata}); end
    m0_if.ren = 1'b0;
    step();
    nrst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (m0_if.ack || m0_if.err || m1_if.ack || m1_if.err) pulses++;
      step();
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_after_pulses got=%0d exp=0", pulses); end
    m1_if.wen = 1'b1; m1_if.addr = 32'h80; m1_if.wdata = 32'hA5A5A5A5;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (m1_if.ack && ack_at < 0) ack_at = c;
      step();
      if (ack_at >= 0) break;
    end
    m1_if.wen = 1'b0;
    checks++; if (ack_at !== 2) begin errors++; $display("FAIL rst_next_ack_cycle got=%0d exp=2", ack_at); end
    step();
  endtask

  initial begin
    checks = 0; errors = 0;
    slave_mode = 0; slave_data = '0;
    nrst = 1'b0;
    m0_if.sel = 1'b0; m0_if.ren = 1'b0; m0_if.wen = 1'b0;
    m0_if.addr = '0; m0_if.wdata = '0; m0_if.width = 2'b00;
    m1_if.sel = 1'b0; m1_if.ren = 1'b0; m1_if.wen = 1'b0;
    m1_if.addr = '0; m1_if.wdata = '0; m1_if.width = 2'b00;
    #2;
    test_reset();
    test_read();
    test_write();
    test_arbitration();
    test_slave_err();
    test_timeout();
    test_drop();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end

endmodule
